// File: rtl/flt2int_seq.sv
// Batch sequencer for the half-precision float-to-integer converter.
// Streams N floats from byte memory through the converter and writes the integer results back.
module flt2int_seq #(
    parameter logic [7:0] SRC_BASE = 8'd4,
    parameter logic [7:0] DST_BASE = 8'd64,
    parameter int         TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  n_ops,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] cycles,
    output logic [7:0]  dm_addr,
    output logic        dm_rd_en,
    output logic        dm_wr_en,
    output logic [7:0]  dm_wdata,
    input  logic [7:0]  dm_rdata,
    output logic        cv_req,
    output logic [15:0] cv_flt,
    input  logic        cv_ack,
    input  logic [15:0] cv_int
);

    // state    | meaning
    // IDLE     | waiting for start
    // RD_HI    | read request for source high byte
    // RD_LO    | read request for low byte, capture high byte
    // CAP      | capture low byte, arm ack timer
    // WAIT_ACK | cv_req high, waiting for ack or timeout
    // WR_HI    | write result high byte
    // WR_LO    | write result low byte, advance operand
    // DONE     | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, RD_HI, RD_LO, CAP, WAIT_ACK, WR_HI, WR_LO, DONE
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [7:0]      n_reg;
    logic [7:0]      idx;
    logic [TW-1:0]   timer;
    logic [15:0]     result;
    logic [7:0]      idx_x2;

    assign idx_x2 = {idx[6:0], 1'b0};
    assign busy   = (state != IDLE) && (state != DONE);
    assign done   = (state == DONE);
    assign cv_req = (state == WAIT_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            n_reg    <= 8'd0;
            idx      <= 8'd0;
            timer    <= '0;
            result   <= 16'd0;
            err      <= 1'b0;
            cycles   <= 16'd0;
            dm_addr  <= 8'd0;
            dm_rd_en <= 1'b0;
            dm_wr_en <= 1'b0;
            dm_wdata <= 8'd0;
            cv_flt   <= 16'd0;
        end else begin
            if (busy && cycles != 16'hFFFF)
                cycles <= cycles + 16'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg  <= n_ops;
                        err    <= 1'b0;
                        cycles <= 16'd0;
                        idx    <= 8'd0;
                        if (n_ops == 8'd0) begin
                            state <= DONE;
                        end else begin
                            state    <= RD_HI;
                            dm_addr  <= SRC_BASE;
                            dm_rd_en <= 1'b1;
                        end
                    end
                end
                RD_HI: begin
                    state   <= RD_LO;
                    dm_addr <= SRC_BASE + idx_x2 + 8'd1;
                end
                RD_LO: begin
                    state        <= CAP;
                    cv_flt[15:8] <= dm_rdata;
                    dm_rd_en     <= 1'b0;
                end
                CAP: begin
                    state       <= WAIT_ACK;
                    cv_flt[7:0] <= dm_rdata;
                    timer       <= TW'(TIMEOUT - 1);
                end
                WAIT_ACK: begin
                    // ack takes priority over an expiring timer
                    if (cv_ack || timer == '0) begin
                        state    <= WR_HI;
                        dm_addr  <= DST_BASE + idx_x2;
                        dm_wr_en <= 1'b1;
                        if (cv_ack) begin
                            result   <= cv_int;
                            dm_wdata <= cv_int[15:8];
                        end else begin
                            result   <= 16'h8000;
                            dm_wdata <= 8'h80;
                            err      <= 1'b1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                WR_HI: begin
                    state    <= WR_LO;
                    dm_addr  <= DST_BASE + idx_x2 + 8'd1;
                    dm_wdata <= result[7:0];
                end
                WR_LO: begin
                    dm_wr_en <= 1'b0;
                    if (idx == n_reg - 8'd1) begin
                        state <= DONE;
                    end else begin
                        state    <= RD_HI;
                        idx      <= idx + 8'd1;
                        dm_addr  <= SRC_BASE + idx_x2 + 8'd2;
                        dm_rd_en <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
